ram_readback_scanner: RTL

//  Read-side counterpart of the receive path's RAM writer. On a start pulse it

---
 rtl/ram_readback_scanner.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_readback_scanner.sv
// Sweeps a synchronous-read RAM from address 0 to DEPTH-1 and streams each
// (addr, data) pair over valid/ready, keeping a running checksum of accepted words.
module ram_readback_scanner #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_e;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

    state_e state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SUM_W-1:0]  checksum_q, checksum_d;

    logic launch;
    logic accept;
    logic wait_last;

    assign launch    = (state_q == S_IDLE) && start;
    assign accept    = (state_q == S_HOLD) && out_ready;
    assign wait_last = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            cnt_q       <= '0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_addr_q  <= ram_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: state_d = S_WAIT;
            S_WAIT: if (cnt_q == CNT_LAST) state_d = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    state_d = (index_q == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port is a flop.
    always_comb begin
        index_d    = index_q;
        cnt_d      = cnt_q;
        checksum_d = checksum_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        if (launch) begin
            index_d    = '0;
            checksum_d = '0;
        end
        if (accept) begin
            checksum_d = checksum_q + SUM_W'(out_data_q);
            if (index_q != LAST_IDX) index_d = index_q + ADDR_W'(1);
        end

        if (state_q == S_READ) begin
            cnt_d = '0;
        end else if ((state_q == S_WAIT) && !wait_last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (wait_last) begin
            out_addr_d = index_q;
            out_data_d = ram_rdata;
        end

        ram_rd_en_d = (state_d == S_READ);
        ram_addr_d  = (state_d == S_READ) ? index_d : ram_addr_q;
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    assign ram_rd_en = ram_rd_en_q;
    assign ram_addr  = ram_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule
